// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: the entry index and the data-array state enum.
package lc3b_types;

  typedef logic [2:0] lc3b_cache_index;

  typedef enum logic [0:0] {
    ARR_IDLE,
    ARR_CLEAR
  } arr_state_e;

endpackage

// File: rtl/cache_array_clear_fsm.sv
// Clear sequencer for the cache data array: owns the IDLE/CLEAR state, the clear
// counter and the ready flag.
module cache_array_clear_fsm
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  output logic                     ready,
  output logic                     clr_en,
  output logic [$clog2(DEPTH)-1:0] clr_addr
);

  localparam int unsigned CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LastCnt = CW'(DEPTH - 1);

  arr_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARR_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARR_IDLE: begin
        if (flush) begin
          state_d = ARR_CLEAR;
          cnt_d   = '0;
        end
      end
      ARR_CLEAR: begin
        if (flush) begin
          cnt_d = '0;
        end else if (cnt_q == LastCnt) begin
          state_d = ARR_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign ready    = (state_q == ARR_IDLE);
  assign clr_en   = (state_q == ARR_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/cache_data_array.sv
// Byte-maskable cache line storage with registered read port and sequenced clear.
// Define CACHE_ARRAY_BYPASS_EN to forward same-cycle write data to a same-index read.
module cache_data_array
  import lc3b_types::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  output logic                     ready,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [WIDTH/8-1:0]       wmask,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;
  localparam logic [IW:0] DepthW = (IW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             clr_en;
  logic [IW-1:0]    clr_addr;
  logic             in_range;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] old_line;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] rd_line;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  cache_array_clear_fsm #(
    .DEPTH (DEPTH)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // Only reachable with a non-power-of-two DEPTH.
  assign in_range = ({1'b0, index} < DepthW);
  assign rd_acc   = rd && ready;
  assign wr_acc   = wr && ready && in_range;

  always_comb begin
    old_line = '0;
    if (in_range) begin
      old_line = mem[index];
    end
  end

  always_comb begin
    merged = old_line;
    for (int b = 0; b < NB; b++) begin
      if (wmask[b]) begin
        merged[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

`ifdef CACHE_ARRAY_BYPASS_EN
  assign rd_line = !in_range ? '0 : (wr_acc ? merged : old_line);
`else
  assign rd_line = old_line;
`endif

  // Clear and accepted writes are mutually exclusive: writes need ready (IDLE).
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[index] <= merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= rd_line;
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_cache_data_array.sv
// Self-checking bench for cache_data_array (DEPTH=8, WIDTH=128) using an expected-read queue.
module tb_cache_data_array;

  localparam int unsigned W  = 128;
  localparam int unsigned D  = 8;
  localparam int unsigned NB = W / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          ready;
  logic          rd;
  logic          wr;
  logic [2:0]    index;
  logic [NB-1:0] wmask;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic          rvalid;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] model [D];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cache_data_array #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .ready  (ready),
    .rd     (rd),
    .wr     (wr),
    .index  (index),
    .wmask  (wmask),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    rd    = 1'b0;
    wr    = 1'b0;
    flush = 1'b0;
    wmask = '0;
  endtask

  task automatic push_rd(int idx, logic [W-1:0] e);
    rd    = 1'b1;
    index = 3'(idx);
    exp_q.push_back(e);
  endtask

  task automatic do_wr(int idx, logic [W-1:0] d, logic [NB-1:0] m);
    wr    = 1'b1;
    index = 3'(idx);
    wdata = d;
    wmask = m;
    tick();
    quiet();
    for (int b = 0; b < NB; b++) begin
      if (m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [W-1:0] e;
    rst = 1'b1;
    quiet();
    index = '0;
    wdata = '0;
    for (int i = 0; i < D; i++) model[i] = '0;
    #12;
    n_vec++;
    if ({ready, rvalid} !== 2'b00 || rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs ready=%b rvalid=%b rdata=%h want 0 0 0", ready, rvalid, rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    n_vec++;
    if (n != 8) begin
      n_bad++;
      $display("FAIL reset_clear_cycles got %0d want 8", n);
    end
    for (int i = 0; i < D; i++) begin
      push_rd(i, model[i]);
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (rvalid !== 1'b1 || rdata !== e) begin
        n_bad++;
        $display("FAIL reset_read idx=%0d rvalid=%b rdata=%h want 1 %h", i, rvalid, rdata, e);
      end
    end
    quiet();
    tick();
    n_vec++;
    if (rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rvalid_pulse rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic test_byte_mask();
    logic [W-1:0] e;
    logic [W-1:0] want;
    want = {{(NB-1){8'hAA}}, 8'h55};
    do_wr(3, {NB{8'hAA}}, '1);
    do_wr(3, {NB{8'h55}}, NB'(1));
    push_rd(3, want);
    tick();
    quiet();
    e = exp_q.pop_front();
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      n_bad++;
      $display("FAIL byte_mask rvalid=%b rdata=%h want 1 %h", rvalid, rdata, e);
    end
    tick();
    n_vec++;
    if (rvalid !== 1'b0 || rdata !== want) begin
      n_bad++;
      $display("FAIL rdata_hold rvalid=%b rdata=%h want 0 %h", rvalid, rdata, want);
    end
    do_wr(3, '0, '0);
    push_rd(3, want);
    tick();
    quiet();
    e = exp_q.pop_front();
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      n_bad++;
      $display("FAIL zero_mask rvalid=%b rdata=%h want 1 %h", rvalid, rdata, e);
    end
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] e;
    wr    = 1'b1;
    wdata = {NB{8'h11}};
    wmask = '1;
`ifdef CACHE_ARRAY_BYPASS_EN
    push_rd(5, {NB{8'h11}});
`else
    push_rd(5, model[5]);
`endif
    tick();
    quiet();
    model[5] = {NB{8'h11}};
    e = exp_q.pop_front();
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      n_bad++;
      $display("FAIL same_cycle rvalid=%b rdata=%h want 1 %h", rvalid, rdata, e);
    end
    push_rd(5, model[5]);
    tick();
    quiet();
    e = exp_q.pop_front();
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      n_bad++;
      $display("FAIL same_cycle_after rvalid=%b rdata=%h want 1 %h", rvalid, rdata, e);
    end
  endtask

  task automatic test_flush();
    int lc;
    logic [W-1:0] e;
    for (int i = 0; i < D; i++) do_wr(i, {NB{8'(i + 1)}}, '1);
    // Write accepted alongside the flush; the clear must wipe it.
    flush = 1'b1;
    wr    = 1'b1;
    index = 3'd2;
    wdata = '1;
    wmask = '1;
    tick();
    quiet();
    n_vec++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_enter ready=%b want 0", ready);
    end
    lc = 0;
    while (ready !== 1'b1 && lc < 40) begin
      if (lc == 4) flush = 1'b1;
      if (lc == 12) begin
        rd    = 1'b1;
        wr    = 1'b1;
        index = 3'd0;
        wdata = '1;
        wmask = '1;
      end
      tick();
      quiet();
      lc++;
      n_vec++;
      if (rvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL clear_drop_rd lc=%0d rvalid=%b want 0", lc, rvalid);
      end
    end
    n_vec++;
    if (lc != 13) begin
      n_bad++;
      $display("FAIL flush_restart_cycles got %0d want 13", lc);
    end
    for (int i = 0; i < D; i++) model[i] = '0;
    for (int i = 0; i < D; i++) begin
      push_rd(i, model[i]);
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (rvalid !== 1'b1 || rdata !== e) begin
        n_bad++;
        $display("FAIL flush_read idx=%0d rvalid=%b rdata=%h want 1 %h", i, rvalid, rdata, e);
      end
    end
    quiet();
    tick();
  endtask

  task automatic test_rst_midread();
    int n;
    logic [W-1:0] e;
    do_wr(1, {NB{8'h77}}, '1);
    rd    = 1'b1;
    index = 3'd1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd  = 1'b0;
    #1;
    n_vec++;
    if ({ready, rvalid} !== 2'b00 || rdata !== '0) begin
      n_bad++;
      $display("FAIL rst_midread ready=%b rvalid=%b rdata=%h want 0 0 0", ready, rvalid, rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if (rvalid !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_rvalid rvalid=%b ready=%b want 0 0", rvalid, ready);
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    wait_ready(n);
    n_vec++;
    if (n != 8) begin
      n_bad++;
      $display("FAIL rst_midclear_cycles got %0d want 8", n);
    end
    for (int i = 0; i < D; i++) model[i] = '0;
    push_rd(1, model[1]);
    tick();
    quiet();
    e = exp_q.pop_front();
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      n_bad++;
      $display("FAIL rst_read rvalid=%b rdata=%h want 1 %h", rvalid, rdata, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_mask();
    test_same_cycle();
    test_flush();
    test_rst_midread();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_data_array.md
CACHE_DATA_ARRAY -- requirements
Module: cache_data_array

Interface
REQ-001 SHALL have parameter WIDTH, default 128, line width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (>=2).
REQ-003 SHALL have port clk, input, 1, sole clock (rising edge).
REQ-004 SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port flush, input, 1, request to clear all entries to zero.
REQ-006 SHALL have port ready, output, 1, high when rd/wr are accepted.
REQ-007 SHALL have port rd, input, 1, read request.
REQ-008 SHALL have port wr, input, 1, write request.
REQ-009 SHALL have port index, input, $clog2(DEPTH), entry select shared by rd and wr.
REQ-010 SHALL have port wmask, input, WIDTH/8, byte-enable (bit i covers wdata[8i+7:8i]).
REQ-011 SHALL have port wdata, input, WIDTH, write data.
REQ-012 SHALL have port rdata, output, WIDTH, registered read data.
REQ-013 SHALL have port rvalid, output, 1, one-cycle pulse marking new rdata.

Function
REQ-014 SHALL accept rd/wr only in a cycle where ready=1; requests with ready=0 are dropped, no side effects.
REQ-015 SHALL write only the bytes with wmask=1 at the edge ending the accept cycle; other bytes keep their value; wmask=0 is a no-op.
REQ-016 SHALL present rdata and rvalid=1 one cycle after an accepted rd; rvalid=0 otherwise; rdata holds its last value between reads.
REQ-017 SHALL treat index>=DEPTH (non-power-of-2 DEPTH) as: write ignored, read returns zero with rvalid=1.
REQ-018 SHALL implement FSM states IDLE and CLEAR; ready=1 only in IDLE.
REQ-019 SHALL, in CLEAR, zero one entry per cycle at counter address 0..DEPTH-1, then enter IDLE after exactly DEPTH cycles.
REQ-020 SHALL go IDLE->CLEAR on flush=1 in IDLE, counter=0; an rd/wr accepted in the same cycle completes first (the write is then zeroed by the clear).
REQ-021 SHALL restart the counter at 0 on flush=1 in CLEAR.
REQ-022 SHALL, with rd and wr accepted to the same index in one cycle, follow the configuration rule in REQ-026/027.

Reset
REQ-023 SHALL, while rst=1, force state=CLEAR, counter=0, rdata=0, rvalid=0, ready=0, independent of clk.
REQ-024 SHALL, after rst deasserts, run the full DEPTH-cycle clear before ready rises; rst asserted mid-clear or mid-read restarts the clear and drops any pending rvalid.

Configuration
REQ-025 SHALL use macro CACHE_ARRAY_BYPASS_EN.
REQ-026 SHALL, with the macro defined, return on same-index rd+wr the merged data (new bytes where wmask=1, old bytes elsewhere).
REQ-027 SHALL, without the macro, return on same-index rd+wr the pre-write contents (read-before-write).

Structure
REQ-028 SHALL take the array-state enum (ARR_IDLE, ARR_CLEAR) from the shared lc3b_types package, next to lc3b_cache_index.
REQ-029 SHALL implement the state register, clear counter and ready in sub-module cache_array_clear_fsm; storage, masking and read port stay in cache_data_array.

Verification
REQ-030 Reset then idle, DEPTH=8 -> ready=0 for exactly 8 cycles after rst falls, then 1; read of every index returns 0.
REQ-031 wr idx 3, wdata=all 0xAA, wmask=all ones; then wr idx 3, wdata=all 0x55, wmask=0x0001; rd idx 3 -> rdata low byte 0x55, other bytes 0xAA, rvalid one cycle after rd.
REQ-032 Same-cycle rd+wr idx 5 (old 0, new all 0x11, full mask) -> all 0x11 with CACHE_ARRAY_BYPASS_EN, 0 without.
REQ-033 Fill all entries, assert flush at clear count 4 -> counter restarts, ready low 8+5 cycles total, all entries read 0; rd/wr during clear are dropped.
REQ-034 rst pulse between accepted rd and its response cycle -> rvalid stays 0, rdata=0, full clear rerun.
